sort_engine: RTL and testbench

//  Parametrised bubble-sort engine for the OLED bar-chart visualisers. Holds N_BARS heights,

---
 rtl/sort_engine.sv | 110 +++++++++++
 tb/tb_sort_engine.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// sort_engine: bubble-sort engine over N_BARS heights with ramp/LFSR loads and a step-paced compare/swap.
module sort_engine #(
    parameter int          N_BARS     = 8,
    parameter int          HEIGHT_W   = 6,
    parameter int          STEP_DELAY = 50_000_000,
    parameter int          RAMP_STEP  = 7,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        load_ramp,
    input  logic                        load_random,
    input  logic                        start,
    input  logic                        pause,
    input  logic                        step,
    input  logic                        descending,
    input  logic [$clog2(N_BARS)-1:0]   rd_idx,
    output logic [HEIGHT_W-1:0]         rd_height,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(N_BARS)-1:0]   cmp_idx,
    output logic [$clog2(N_BARS):0]     sorted_from,
    output logic [15:0]                 swap_count
);
    localparam int IW = $clog2(N_BARS);
    localparam int DW = STEP_DELAY > 1 ? $clog2(STEP_DELAY) : 1;
    localparam logic [IW:0] NB = (IW+1)'(N_BARS);
    localparam logic [IW:0] LAST = (IW+1)'(N_BARS - 2);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state;
    logic [HEIGHT_W-1:0] bar [N_BARS];
    logic [15:0] lfsr;
    logic [IW-1:0] i, j, jn, k;
    logic [DW-1:0] delay;
    logic desc, pass_swapped, fire, ooo, pass_end;
    logic [HEIGHT_W-1:0] a, b;
    always_comb begin
        jn = j + 1'b1;
        a = bar[j];
        b = bar[jn];
        ooo = desc ? a < b : a > b;
        fire = state == RUN && (pause ? step : delay == DW'(STEP_DELAY - 1));
        pass_end = {1'b0, j} == LAST - {1'b0, i};
    end
    assign rd_height = (int'(rd_idx) < N_BARS) ? bar[rd_idx] : '0;
    assign busy = state == LOAD || state == RUN;
    assign done = state == DONE;
    assign cmp_idx = j;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            for (int n = 0; n < N_BARS; n++) bar[n] <= HEIGHT_W'((n + 1) * RAMP_STEP);
            lfsr <= LFSR_SEED;
            i <= '0;
            j <= '0;
            k <= '0;
            delay <= '0;
            desc <= 1'b0;
            pass_swapped <= 1'b0;
            sorted_from <= NB;
            swap_count <= '0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            case (state)
                IDLE, DONE: if (load_ramp || load_random || start) begin
                    swap_count <= '0;
                    sorted_from <= NB;
                    i <= '0;
                    j <= '0;
                    k <= '0;
                    delay <= '0;
                    pass_swapped <= 1'b0;
                    state <= load_ramp ? IDLE : load_random ? LOAD : RUN;
                    if (load_ramp)
                        for (int n = 0; n < N_BARS; n++) bar[n] <= HEIGHT_W'((n + 1) * RAMP_STEP);
                    if (!load_ramp && !load_random) desc <= descending;
                end
                LOAD: begin
                    bar[k] <= lfsr[HEIGHT_W-1:0];
                    k <= k + 1'b1;
                    if (k == IW'(N_BARS - 1)) state <= IDLE;
                end
                RUN: begin
                    if (fire) delay <= '0;
                    else if (!pause) delay <= delay + 1'b1;
                    if (fire) begin
                        if (ooo) begin
                            bar[j] <= b;
                            bar[jn] <= a;
                            swap_count <= swap_count + 16'(swap_count != 16'hFFFF);
                        end
                        if (!pass_end) begin
                            j <= jn;
                            pass_swapped <= pass_swapped || ooo;
                        end else if (!(pass_swapped || ooo) || {1'b0, i} == LAST) begin
                            sorted_from <= '0;
                            state <= DONE;
                        end else begin
                            sorted_from <= NB - 1'b1 - {1'b0, i};
                            i <= i + 1'b1;
                            j <= '0;
                            pass_swapped <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: table, hand-sequence and randomized checks of sort_engine against a behavioural model.
module tb_sort_engine;
    localparam int N = 5;
    logic clk = 0, reset_n = 0, load_ramp = 0, load_random = 0, start = 0;
    logic pause = 0, step = 0, descending = 0;
    logic [2:0] rd_idx = 0;
    logic [5:0] rd_height;
    logic busy, done;
    logic [2:0] cmp_idx;
    logic [3:0] sorted_from;
    logic [15:0] swap_count;
    int checks = 0, errors = 0;
    logic [15:0] m_lfsr;
    int m [N];
    typedef struct {logic [2:0] idx; logic [5:0] exp;} vec_t;
    vec_t tbl [8];

    sort_engine #(.N_BARS(N), .HEIGHT_W(6), .STEP_DELAY(2), .RAMP_STEP(10), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset_n(reset_n), .load_ramp(load_ramp), .load_random(load_random),
        .start(start), .pause(pause), .step(step), .descending(descending), .rd_idx(rd_idx),
        .rd_height(rd_height), .busy(busy), .done(done), .cmp_idx(cmp_idx),
        .sorted_from(sorted_from), .swap_count(swap_count)
    );

    always #10 clk = ~clk;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic set_ramp();
        for (int p = 0; p < N; p++) m[p] = ((p + 1) * 10) % 64;
    endtask

    task automatic chk_bars(input string name);
        for (int p = 0; p < N; p++) begin
            rd_idx = 3'(p);
            #1 chk($sformatf("%s bar%0d", name, p), 32'(rd_height), 32'(m[p]));
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, " busy"}, 32'(busy), 0);
        chk({name, " done"}, 32'(done), 0);
        chk({name, " sorted_from"}, 32'(sorted_from), 5);
        chk({name, " swap_count"}, 32'(swap_count), 0);
        chk({name, " cmp_idx"}, 32'(cmp_idx), 0);
        set_ramp();
        chk_bars(name);
    endtask

    task automatic pulse_start(input logic d);
        descending = d;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic do_ramp();
        load_ramp = 1;
        @(negedge clk);
        load_ramp = 0;
        set_ramp();
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, " done"}, 32'(done), 1);
    endtask

    // expected result: strict inversions give the swap count, then any plain sort gives the final order
    task automatic model_sort(input logic d, output int inv);
        int t;
        inv = 0;
        for (int p = 0; p < N; p++)
            for (int q = p + 1; q < N; q++)
                if (d ? m[p] < m[q] : m[p] > m[q]) inv++;
        for (int p = 0; p < N; p++)
            for (int q = p + 1; q < N; q++)
                if (d ? m[q] > m[p] : m[q] < m[p]) begin
                    t = m[p];
                    m[p] = m[q];
                    m[q] = t;
                end
    endtask

    task automatic do_sort(input string name, input logic d, input int exp_cycles);
        int n, inv;
        pulse_start(d);
        wait_done(name, n);
        model_sort(d, inv);
        chk({name, " swap_count"}, 32'(swap_count), 32'(inv));
        chk({name, " sorted_from"}, 32'(sorted_from), 0);
        chk({name, " busy"}, 32'(busy), 0);
        if (exp_cycles >= 0) chk({name, " cycles"}, 32'(n), 32'(exp_cycles));
        chk_bars(name);
    endtask

    task automatic do_random_load(input string name);
        load_random = 1;
        @(negedge clk);
        load_random = 0;
        for (int p = 0; p < N; p++) begin
            chk($sformatf("%s busy%0d", name, p), 32'(busy), 1);
            m[p] = int'(m_lfsr[5:0]);
            @(negedge clk);
        end
        chk({name, " busy_end"}, 32'(busy), 0);
        chk_bars(name);
    endtask

    initial begin
        int n;
        for (int p = 0; p < 8; p++) tbl[p] = '{3'(p), p < N ? 6'((p + 1) * 10) : 6'd0};
        repeat (2) @(negedge clk);
        chk_reset("reset");
        for (int p = 0; p < 8; p++) begin
            rd_idx = tbl[p].idx;
            #1 chk($sformatf("reset rd%0d", p), 32'(rd_height), 32'(tbl[p].exp));
        end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        do_sort("asc_sorted", 0, 8);
        repeat (5) @(negedge clk);
        chk("done_hold", 32'(done), 1);
        do_sort("desc_ramp", 1, 20);

        pulse_start(0);
        n = 0;
        while (cmp_idx != 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pause reach", 32'(cmp_idx), 1);
        pause = 1;
        repeat (100) @(negedge clk);
        chk("pause cmp_idx", 32'(cmp_idx), 1);
        chk("pause swaps", 32'(swap_count), 1);
        m = '{40, 50, 30, 20, 10};
        chk_bars("pause");
        step = 1;
        @(negedge clk);
        step = 0;
        repeat (3) @(negedge clk);
        chk("step cmp_idx", 32'(cmp_idx), 2);
        chk("step swaps", 32'(swap_count), 2);
        m = '{40, 30, 50, 20, 10};
        chk_bars("step");
        pause = 0;
        wait_done("after_pause", n);
        chk("after_pause swaps", 32'(swap_count), 10);
        set_ramp();
        chk_bars("after_pause");

        load_ramp = 1;
        start = 1;
        @(negedge clk);
        load_ramp = 0;
        start = 0;
        repeat (10) @(negedge clk);
        chk("prio busy", 32'(busy), 0);
        chk("prio done", 32'(done), 0);
        chk("prio swaps", 32'(swap_count), 0);
        chk("prio sorted_from", 32'(sorted_from), 5);

        for (int t = 0; t < 20; t++) begin
            repeat ($urandom_range(0, 7)) @(negedge clk);
            do_random_load($sformatf("rnd%0d load", t));
            do_sort($sformatf("rnd%0d sort", t), 1'($urandom_range(0, 1)), -1);
        end

        do_ramp();
        pulse_start(1);
        repeat (7) @(negedge clk);
        reset_n = 0;
        #1 chk_reset("reset_run");
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        load_random = 1;
        @(negedge clk);
        load_random = 0;
        repeat (2) @(negedge clk);
        chk("load busy", 32'(busy), 1);
        reset_n = 0;
        #1 chk_reset("reset_load");
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
